// File: rtl/frame_window_mem.sv
// frame_window_mem: ping-pong frame store. The producer writes one pixel per
// cycle into the write bank while the filter reads a full 3x3 window per cycle
// from the read bank. Window taps that fall outside the frame are resolved by
// the selected border mode instead of wrapping on the address bits.

// fwm_tap: resolves one window tap (offset DR,DC from the origin) to an in-frame
// row/column, or flags it as a zero tap in zero-pad mode.
module fwm_tap #(
   parameter int ADDR_W      = 8,
   parameter int IMG_W       = 256,
   parameter int IMG_H       = 256,
   parameter int BORDER_MODE = 0,
   parameter int DR          = 0,
   parameter int DC          = 0
) (
   input  logic [ADDR_W-1:0] row,
   input  logic [ADDR_W-1:0] col,
   output logic [ADDR_W-1:0] res_row,
   output logic [ADDR_W-1:0] res_col,
   output logic              zero
);
   // two extra bits so origin + 2 never overflows
   localparam int            CW  = ADDR_W + 2;
   localparam logic [CW-1:0] H_C = CW'(IMG_H);
   localparam logic [CW-1:0] W_C = CW'(IMG_W);

   logic [CW-1:0] r, c, r_res, c_res;

   assign r = {2'b00, row} + CW'(DR);
   assign c = {2'b00, col} + CW'(DC);

   // border resolution; each tap is handled on its own
   always_comb begin
      r_res = r;
      c_res = c;
      zero  = 1'b0;
      case (BORDER_MODE)
         1: begin
            if (r >= H_C) r_res = H_C - CW'(1);
            if (c >= W_C) c_res = W_C - CW'(1);
         end
         2: begin
            r_res = r % H_C;
            c_res = c % W_C;
         end
         default: begin
            zero = (r >= H_C) || (c >= W_C);
            // keep the array index in range even though the tap is forced to 0
            if (zero) begin
               r_res = '0;
               c_res = '0;
            end
         end
      endcase
   end

   // resolved coordinates are below IMG_H/IMG_W, so they fit in ADDR_W bits
   assign res_row = ADDR_W'(r_res);
   assign res_col = ADDR_W'(c_res);
endmodule

module frame_window_mem #(
   parameter int PIX_W       = 8,
   parameter int IMG_W       = 256,
   parameter int IMG_H       = 256,
   parameter int ADDR_W      = 8,
   parameter int BORDER_MODE = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  addr_row_w,
   input  logic [ADDR_W-1:0]  addr_col_w,
   input  logic [PIX_W-1:0]   wr_pixel,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  addr_row_r,
   input  logic [ADDR_W-1:0]  addr_col_r,
   input  logic               swap,
   output logic [9*PIX_W-1:0] win,
   output logic               win_valid,
   output logic               rd_bank,
   output logic               wr_drop
);
   localparam int            TAPS   = 9;
   localparam int            STAGES = 2;
   localparam int            DEPTH  = 2 * IMG_H * IMG_W;
   localparam int            IW     = $clog2(DEPTH);
   localparam int            CW     = ADDR_W + 2;
   localparam logic [CW-1:0] H_C    = CW'(IMG_H);
   localparam logic [CW-1:0] W_C    = CW'(IMG_W);

   typedef struct packed {
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
      logic              bank;
   } rd_req_t;

   typedef struct packed {
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
      logic [PIX_W-1:0]  data;
      logic              bank;
   } wr_req_t;

   // both banks in one flat array: bank is the most significant index part
   logic [PIX_W-1:0] mem [DEPTH];

   // vld_pipe[0]: origin captured, [1]: taps resolved, [2]: window out
   logic [STAGES:0]                vld_pipe;
   rd_req_t                        rq;
   logic [TAPS-1:0][ADDR_W-1:0]    t_row, t_col;
   logic [TAPS-1:0]                t_zero;
   logic [TAPS-1:0][IW-1:0]        s2_idx;
   logic [TAPS-1:0]                s2_zero;
   logic [TAPS-1:0][PIX_W-1:0]     win_q;

   wr_req_t                        wq;
   logic                           wq_vld;
   logic                           wq_ok;
   logic [IW-1:0]                  wq_idx;

   function automatic logic [IW-1:0] mem_idx(input logic bank,
                                             input logic [ADDR_W-1:0] row,
                                             input logic [ADDR_W-1:0] col);
      int i;
      i = (bank ? IMG_H * IMG_W : 0) + int'(row) * IMG_W + int'(col);
      return IW'(i);
   endfunction

   assign win       = win_q;
   assign win_valid = vld_pipe[STAGES];

   // swap flips the read bank on the edge where it is sampled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_bank <= 1'b0;
      else      rd_bank <= rd_bank ^ swap;
   end

   // read stage 0: capture origin with the pre-swap read bank
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         rq       <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], rd_en};
         if (rd_en) rq <= '{row: addr_row_r, col: addr_col_r, bank: rd_bank};
      end
   end

   // one border resolver per tap
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      fwm_tap #(
         .ADDR_W      (ADDR_W),
         .IMG_W       (IMG_W),
         .IMG_H       (IMG_H),
         .BORDER_MODE (BORDER_MODE),
         .DR          (k / 3),
         .DC          (k % 3)
      ) u_tap (
         .row     (rq.row),
         .col     (rq.col),
         .res_row (t_row[k]),
         .res_col (t_col[k]),
         .zero    (t_zero[k])
      );
   end

   // read stage 1: register resolved tap addresses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_idx  <= '0;
         s2_zero <= '0;
      end else if (vld_pipe[0]) begin
         for (int k = 0; k < TAPS; k++) begin
            s2_idx[k]  <= mem_idx(rq.bank, t_row[k], t_col[k]);
            s2_zero[k] <= t_zero[k];
         end
      end
   end

   // read stage 2: fetch all nine taps; window holds when the slot is idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q <= '0;
      end else if (vld_pipe[1]) begin
         for (int k = 0; k < TAPS; k++)
            win_q[k] <= s2_zero[k] ? '0 : mem[s2_idx[k]];
      end
   end

   assign wq_ok  = ({2'b00, wq.row} < H_C) && ({2'b00, wq.col} < W_C);
   assign wq_idx = mem_idx(wq.bank, wq.row, wq.col);

   // write capture targets the bank not being read at this edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wq_vld  <= 1'b0;
         wq      <= '0;
         wr_drop <= 1'b0;
      end else begin
         wq_vld  <= wr_en;
         if (wr_en)
            wq <= '{row: addr_row_w, col: addr_col_w, data: wr_pixel, bank: ~rd_bank};
         wr_drop <= wq_vld && !wq_ok;
      end
   end

   // array update one edge after capture; no reset so contents survive rst
   always_ff @(posedge clk) begin
      if (wq_vld && wq_ok) mem[wq_idx] <= wq.data;
   end
endmodule
